// File: rtl/alu_request_arbiter_pkg.sv
// Shared ALU types: one-hot operation flags plus the request/result bundles
// that travel through the arbiter's operand and result registers.
package alu_request_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic op_add;
        logic op_sub;
        logic op_and;
        logic op_or;
        logic op_xor;
        logic op_sll;
        logic op_srl;
        logic op_sra;
        logic op_slt;
        logic op_sltu;
        logic op_eq_b;
        logic op_ne_b;
        logic op_slt_b;
        logic op_sltu_b;
    } InstructionSetALU;

    typedef struct packed {
        InstructionSetALU  op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [DATA_W-1:0] in1_b;
        logic [DATA_W-1:0] in2_b;
    } AluRequest;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic              out_b;
    } AluResult;

endpackage

// File: rtl/alu_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid bit at or after rr_ptr,
// wrapping; grant is suppressed when enable is low but idx still reports it.
module alu_request_arbiter_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int pos;
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && valid[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
        if (found && enable) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// operand register (S1) feeding the ALU, result register (S2) routed by tag.
module alu_request_arbiter
    import alu_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  InstructionSetALU [NUM_REQ-1:0] req_op,
    input  logic [NUM_REQ-1:0][31:0]       req_in1,
    input  logic [NUM_REQ-1:0][31:0]       req_in2,
    input  logic [NUM_REQ-1:0][31:0]       req_in1_b,
    input  logic [NUM_REQ-1:0][31:0]       req_in2_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [31:0]                    rsp_out,
    output logic                           rsp_out_b,
    output InstructionSetALU               alu_op,
    output logic [31:0]                    alu_in1,
    output logic [31:0]                    alu_in2,
    output logic [31:0]                    alu_in1_b,
    output logic [31:0]                    alu_in2_b,
    input  logic [31:0]                    alu_out,
    input  logic                           alu_out_b
);

    AluRequest          req_bus [NUM_REQ];
    logic               s1_valid_reg;
    AluRequest          s1_req_reg;
    logic [IDX_W-1:0]   s1_tag_reg;
    logic               s2_valid_reg;
    AluResult           s2_res_reg;
    logic [IDX_W-1:0]   s2_tag_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic               s2_drain;
    logic               s1_adv;
    logic               can_accept;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    AluRequest          alu_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bus[gi] = '{op: req_op[gi], in1: req_in1[gi], in2: req_in2[gi],
                                   in1_b: req_in1_b[gi], in2_b: req_in2_b[gi]};
            assign rsp_valid[gi] = s2_valid_reg && (s2_tag_reg == IDX_W'(gi));
        end
    endgenerate

    assign s2_drain   = s2_valid_reg & rsp_ready[s2_tag_reg];
    assign s1_adv     = s1_valid_reg & (~s2_valid_reg | s2_drain);
    assign can_accept = ~s1_valid_reg | s1_adv;

    // Reset also masks the grant so nothing looks accepted while it is held.
    alu_request_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_reg),
        .enable (can_accept & ~reset),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready   = grant;
    assign accept      = |grant;
    assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    assign alu_req   = s1_valid_reg ? s1_req_reg : '0;
    assign alu_op    = alu_req.op;
    assign alu_in1   = alu_req.in1;
    assign alu_in2   = alu_req.in2;
    assign alu_in1_b = alu_req.in1_b;
    assign alu_in2_b = alu_req.in2_b;

    assign rsp_out   = s2_res_reg.out;
    assign rsp_out_b = s2_res_reg.out_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_req_reg   <= '0;
            s1_tag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_res_reg   <= '0;
            s2_tag_reg   <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_req_reg   <= req_bus[grant_idx];
                s1_tag_reg   <= grant_idx;
                rr_ptr_reg   <= rr_ptr_next;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
            // A drain and an advance in the same cycle simply reload S2.
            if (s1_adv) begin
                s2_valid_reg <= 1'b1;
                s2_res_reg   <= '{out: alu_out, out_b: alu_out_b};
                s2_tag_reg   <= s1_tag_reg;
            end else if (s2_drain) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Randomised and directed bench for alu_request_arbiter; the reference model
// is a 2-entry in-order queue whose head is visible two cycles after accept.
module tb_alu_request_arbiter;
    import alu_request_arbiter_pkg::*;

    localparam int N = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    InstructionSetALU [N-1:0] req_op;
    logic [N-1:0][31:0]       req_in1, req_in2, req_in1_b, req_in2_b;
    logic [N-1:0]             rsp_valid;
    logic [N-1:0]             rsp_ready;
    logic [31:0]              rsp_out;
    logic                     rsp_out_b;
    InstructionSetALU         alu_op;
    logic [31:0]              alu_in1, alu_in2, alu_in1_b, alu_in2_b;
    logic [31:0]              alu_out;
    logic                     alu_out_b;
    AluResult                 alu_res;

    alu_request_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_in1(req_in1), .req_in2(req_in2), .req_in1_b(req_in1_b), .req_in2_b(req_in2_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_out_b(rsp_out_b),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_in1_b(alu_in1_b), .alu_in2_b(alu_in2_b),
        .alu_out(alu_out), .alu_out_b(alu_out_b)
    );

    always #5 clk = ~clk;

    function automatic AluResult alu_ref(InstructionSetALU op, logic [31:0] a, logic [31:0] b,
                                         logic [31:0] ab, logic [31:0] bb);
        AluResult r;
        r = '0;
        if (op.op_add)       r.out = a + b;
        else if (op.op_sub)  r.out = a - b;
        else if (op.op_and)  r.out = a & b;
        else if (op.op_or)   r.out = a | b;
        else if (op.op_xor)  r.out = a ^ b;
        else if (op.op_sll)  r.out = a << b[4:0];
        else if (op.op_srl)  r.out = a >> b[4:0];
        else if (op.op_sra)  r.out = 32'($signed(a) >>> b[4:0]);
        else if (op.op_slt)  r.out = {31'b0, $signed(a) < $signed(b)};
        else if (op.op_sltu) r.out = {31'b0, a < b};
        if (op.op_eq_b)        r.out_b = (ab == bb);
        else if (op.op_ne_b)   r.out_b = (ab != bb);
        else if (op.op_slt_b)  r.out_b = ($signed(ab) < $signed(bb));
        else if (op.op_sltu_b) r.out_b = (ab < bb);
        return r;
    endfunction

    // Stand-in for the shared ALU.
    always_comb alu_res = alu_ref(alu_op, alu_in1, alu_in2, alu_in1_b, alu_in2_b);
    assign alu_out   = alu_res.out;
    assign alu_out_b = alu_res.out_b;

    typedef struct {
        int        tag;
        AluRequest req;
        AluResult  res;
        int        ready_cyc;
    } item_t;

    item_t     q[$];
    int        total = 0, bad = 0, cyc = 0, rr = 0;
    logic [N-1:0] exp_req_ready, obs_req_ready, exp_rsp_valid, obs_rsp_valid;
    AluResult  exp_res, obs_res;
    AluRequest exp_alu, obs_alu;

    function automatic InstructionSetALU rand_op();
        logic [$bits(InstructionSetALU)-1:0] v;
        v = '0;
        if ($urandom_range(0, 9) == 0) v = $bits(InstructionSetALU)'($urandom);
        else v[$urandom_range(0, $bits(InstructionSetALU) - 1)] = 1'b1;
        return InstructionSetALU'(v);
    endfunction

    task automatic set_req(int i, InstructionSetALU op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] ab, logic [31:0] bb);
        req_op[i] = op; req_in1[i] = a; req_in2[i] = b; req_in1_b[i] = ab; req_in2_b[i] = bb;
    endtask

    task automatic rand_req(int i);
        set_req(i, rand_op(), $urandom, $urandom_range(0, 40), $urandom, $urandom);
    endtask

    // One clock: capture DUT outputs and model expectations, then advance the model.
    task automatic step();
        bit present, drain, found;
        int g;
        item_t it;
        #1;
        present = (q.size() > 0) && (cyc >= q[0].ready_cyc);
        exp_rsp_valid = present ? N'(1 << q[0].tag) : '0;
        exp_res = present ? q[0].res : '0;
        drain = present && rsp_ready[q[0].tag];
        found = 0; g = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (!found && req_valid[i]) begin found = 1; g = i; end
        end
        found = found && ((q.size() < 2) || drain);
        exp_req_ready = found ? N'(1 << g) : '0;
        if (q.size() == 2)                exp_alu = q[1].req;
        else if (q.size() == 1 && !present) exp_alu = q[0].req;
        else                              exp_alu = '0;
        obs_req_ready = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_res = '{out: rsp_out, out_b: rsp_out_b};
        obs_alu = '{op: alu_op, in1: alu_in1, in2: alu_in2, in1_b: alu_in1_b, in2_b: alu_in2_b};
        if (found) begin
            it.tag = g;
            it.req = '{op: req_op[g], in1: req_in1[g], in2: req_in2[g],
                       in1_b: req_in1_b[g], in2_b: req_in2_b[g]};
            it.res = alu_ref(it.req.op, it.req.in1, it.req.in2, it.req.in1_b, it.req.in2_b);
            it.ready_cyc = cyc + 2;
        end
        @(posedge clk);
        if (drain) void'(q.pop_front());
        if (found) begin q.push_back(it); rr = (g + 1) % N; end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain_pipe();
        req_valid = '0; rsp_ready = '1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; rsp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, '0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if ({rsp_out, rsp_out_b} !== 33'd0) begin bad++; $display("FAIL reset_rsp_out got=%h/%b want=0", rsp_out, rsp_out_b); end
        total++; if (alu_op !== '0) begin bad++; $display("FAIL reset_alu_op got=%h want=0", alu_op); end
        total++; if ({alu_in1, alu_in2, alu_in1_b, alu_in2_b} !== 128'd0) begin
            bad++; $display("FAIL reset_alu_in got=%h %h %h %h want=0", alu_in1, alu_in2, alu_in1_b, alu_in2_b); end
        @(negedge clk);
        reset = 1'b0; req_valid = '0;
        q.delete(); rr = 0;
    endtask

    task automatic test_single();
        InstructionSetALU op;
        op = '0; op.op_add = 1'b1;
        set_req(0, op, 32'd5, 32'd7, 0, 0);
        req_valid = 2'b01; rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            step();
            req_valid = '0;
            total++; if (obs_rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL single_rsp1 k=%0d got=%b want=0", k, obs_rsp_valid[1]); end
            if (k == 0) begin
                total++; if (obs_req_ready !== 2'b01 || obs_req_ready !== exp_req_ready) begin
                    bad++; $display("FAIL single_ready got=%b want=01", obs_req_ready); end
            end
            if (k == 1) begin
                total++; if (obs_alu !== exp_alu || obs_alu.in1 !== 32'd5 || !obs_alu.op.op_add) begin
                    bad++; $display("FAIL single_alu got=%h want=%h", obs_alu, exp_alu); end
            end
            if (k == 2) begin
                total++; if (obs_rsp_valid !== 2'b01 || obs_res.out !== 32'd12) begin
                    bad++; $display("FAIL single_rsp got=%b/%0d want=01/12", obs_rsp_valid, obs_res.out); end
            end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] hist [8];
        InstructionSetALU op;
        op = '0; op.op_add = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, op, $urandom, $urandom, 0, 0);
        rsp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 6) ? '1 : '0;
            step();
            hist[k] = obs_req_ready;
            for (int i = 0; i < N; i++) if (obs_req_ready[i]) set_req(i, op, $urandom, $urandom, 0, 0);
            total++; if (obs_req_ready !== exp_req_ready) begin
                bad++; $display("FAIL cont_grant k=%0d got=%b want=%b", k, obs_req_ready, exp_req_ready); end
            if (k > 0 && k < 6) begin
                total++; if (obs_req_ready !== ~hist[k-1]) begin
                    bad++; $display("FAIL cont_alternate k=%0d got=%b want=%b", k, obs_req_ready, ~hist[k-1]); end
            end
            if (k >= 2) begin
                total++; if (obs_rsp_valid !== hist[k-2] || obs_res !== exp_res) begin
                    bad++; $display("FAIL cont_rsp k=%0d got=%b/%h want=%b/%h", k, obs_rsp_valid, obs_res, hist[k-2], exp_res); end
            end
        end
    endtask

    task automatic test_backpressure();
        InstructionSetALU op;
        int n_acc = 0, n_rsp = 0;
        logic held;
        logic [31:0] prev_out;
        op = '0; op.op_sub = 1'b1;
        set_req(0, op, 32'd10, 32'd3, 0, 0);
        held = 1'b0; prev_out = '0;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 6) ? 2'b01 : 2'b00;
            rsp_ready = (k >= 2 && k < 5) ? 2'b10 : 2'b11;
            step();
            if (obs_req_ready[0]) n_acc++;
            if (obs_rsp_valid[0] && rsp_ready[0]) n_rsp++;
            total++; if (obs_req_ready !== exp_req_ready || obs_rsp_valid !== exp_rsp_valid) begin
                bad++; $display("FAIL bp_hs k=%0d got=%b/%b want=%b/%b", k, obs_req_ready, obs_rsp_valid, exp_req_ready, exp_rsp_valid); end
            if (obs_rsp_valid[0]) begin
                total++; if (obs_res.out !== 32'd7 || (held && obs_res.out !== prev_out)) begin
                    bad++; $display("FAIL bp_result k=%0d got=%0d want=7", k, obs_res.out); end
            end else if (held) begin
                total++; bad++; $display("FAIL bp_dropped k=%0d got=rsp_valid 0 want=1", k);
            end
            held = obs_rsp_valid[0] && !rsp_ready[0];
            prev_out = obs_res.out;
        end
        total++; if (n_rsp !== n_acc || n_acc < 3) begin
            bad++; $display("FAIL bp_count got=%0d rsp want=%0d (accepts)", n_rsp, n_acc); end
    endtask

    task automatic test_secondary();
        InstructionSetALU op;
        logic want [2] = '{1'b1, 1'b0};
        int n = 0;
        rsp_ready = '1; req_valid = 2'b10;
        op = '0; op.op_slt_b = 1'b1;
        set_req(1, op, 0, 0, 32'hFFFF_FFFF, 32'd1);
        step();
        op = '0; op.op_sltu_b = 1'b1;
        set_req(1, op, 0, 0, 32'hFFFF_FFFF, 32'd1);
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs_rsp_valid[1] && n < 2) begin
                total++; if (obs_res.out_b !== want[n] || obs_res !== exp_res) begin
                    bad++; $display("FAIL secondary_b n=%0d got=%b want=%b", n, obs_res.out_b, want[n]); end
                n++;
            end
        end
        total++; if (n !== 2) begin bad++; $display("FAIL secondary_count got=%0d want=2", n); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1; rsp_ready = '0;
        repeat (3) step();
        total++; if (obs_rsp_valid === '0 || obs_req_ready !== '0) begin
            bad++; $display("FAIL rmid_full got=%b/%b want=nonzero/0", obs_rsp_valid, obs_req_ready); end
        #2 reset = 1'b1;
        #1;
        total++; if (rsp_valid !== '0 || req_ready !== '0 || alu_op !== '0) begin
            bad++; $display("FAIL rmid_async got=%b/%b/%h want=0/0/0", rsp_valid, req_ready, alu_op); end
        q.delete(); rr = 0;
        @(negedge clk);
        reset = 1'b0; rsp_ready = '1;
        step();
        total++; if (obs_req_ready !== 2'b01 || obs_req_ready !== exp_req_ready) begin
            bad++; $display("FAIL rmid_first_grant got=%b want=01", obs_req_ready); end
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (obs_alu !== '0 || obs_req_ready !== '0) begin
                bad++; $display("FAIL idle k=%0d got=%h/%b want=0/0", k, obs_alu, obs_req_ready); end
        end
        req_valid = '1;
        step();
        total++; if (obs_req_ready !== exp_req_ready) begin
            bad++; $display("FAIL idle_rr got=%b want=%b", obs_req_ready, exp_req_ready); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom | $urandom);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 2) == 0) rand_req(i);
            step();
            total++; if (obs_req_ready !== exp_req_ready) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, obs_req_ready, exp_req_ready); end
            total++; if (obs_rsp_valid !== exp_rsp_valid) begin
                bad++; $display("FAIL rand_rsp_valid cyc=%0d got=%b want=%b", cyc, obs_rsp_valid, exp_rsp_valid); end
            if (exp_rsp_valid != '0) begin
                total++; if (obs_res !== exp_res) begin
                    bad++; $display("FAIL rand_rsp_data cyc=%0d got=%h want=%h", cyc, obs_res, exp_res); end
            end
            total++; if (obs_alu !== exp_alu) begin
                bad++; $display("FAIL rand_alu cyc=%0d got=%h want=%h", cyc, obs_alu, exp_alu); end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        req_op = '0; req_in1 = '0; req_in2 = '0; req_in1_b = '0; req_in2_b = '0;
        test_reset();
        test_single();
        drain_pipe();
        test_contention();
        drain_pipe();
        test_backpressure();
        drain_pipe();
        test_secondary();
        drain_pipe();
        test_reset_mid();
        drain_pipe();
        test_idle();
        drain_pipe();
        test_random();
        drain_pipe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
